instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage directly upstream of the multicycle control unit. It owns the program counter, fetches one 32-bit instruction per request from instruction memory over a req/ack handshake, and holds it in an instruction register driven onto the control unit's `instr` input. It applies PC updates (+4, branch/jump target) commanded by the control unit, and flags memory timeouts.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `MAX_WAIT`, default 255: maximum number of request cycles without ack before a timeout; legal range 1..255.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `fetch_en` in 1: start a fetch at the current PC.
- `pc_inc` in 1: PC <= PC + 4.
- `pc_load` in 1: PC <= `pc_target`.
- `pc_target` in 32: branch/JAL target address.
- `imem_req` out 1: memory read request.
- `imem_addr` out 32: read address, equal to the PC register.
- `imem_ack` in 1: read data valid this cycle.
- `imem_rdata` in 32: read data.
- `instr` out 32: instruction register, drives the control unit.
- `instr_valid` out 1: `instr` holds the word fetched from the current PC.
- `pc` out 32: current PC register.
- `pc_plus4` out 32: `pc` + 4, combinational.
- `fetch_err` out 1: sticky timeout error.
- `misalign_err` out 1: one-cycle pulse on a rejected misaligned `pc_load`.

## Operation
- Reset values: `pc`=RESET_PC, `instr`=32'h0000_0013 (NOP), `instr_valid`=0, `imem_req`=0, `fetch_err`=0, `misalign_err`=0, state IDLE, wait counter=0.
- States:
  - IDLE: no valid instruction.
  - REQ: request outstanding.
  - VALID: `instr` held.
  - ERR: dead until reset.
- Transitions:
  - IDLE, `fetch_en` -> REQ.
  - REQ, `imem_ack` -> VALID; `instr` <= `imem_rdata`.
  - REQ, no ack, counter == MAX_WAIT-1 -> ERR.
  - VALID, `fetch_en` -> REQ.
  - ERR -> ERR.
- `imem_req` = (state == REQ). `imem_addr` = `pc` at all times; it is stable throughout REQ.
- `instr_valid` = (state == VALID). `instr` keeps its last value in every other state.
- PC update:
  - Accepted only in IDLE and VALID. `pc_inc`/`pc_load` in REQ or ERR are dropped.
  - `pc_load` takes priority over `pc_inc` when both are asserted.
  - Any accepted PC update in VALID also moves the state to IDLE (the held instruction is stale), unless `fetch_en` is asserted in the same cycle, which moves it to REQ.
- `fetch_en` and a PC update in the same cycle: the PC updates at the edge, and REQ then fetches from the new PC.
- Arithmetic is modulo 2^32: `pc`=32'hFFFF_FFFC gives `pc_plus4`=0, and `pc_inc` wraps to 0.
- Wait counter is 8 bits. It clears on REQ entry and increments each REQ cycle without ack.
- `imem_ack` outside REQ is ignored.
- ERR: `fetch_err`=1, `imem_req`=0, all inputs ignored; exited only by `rst_n`.

## Timing
- `fetch_en` sampled at edge N -> `imem_req` high during cycle N+1.
- Ack in the same cycle as `imem_req` -> `instr`/`instr_valid` updated at that edge and visible the following cycle. Minimum latency is 2 cycles from `fetch_en` to `instr_valid`.
- Timeout: ERR is entered at the edge ending the MAX_WAIT-th un-acked request cycle. An ack in that final cycle wins over the timeout.
- PC update is visible on `pc`/`imem_addr` the cycle after `pc_inc`/`pc_load`.
- Reset during REQ: `imem_req` low the cycle after `rst_n` is sampled low; a late ack is ignored.

## Configuration
- Macro: `FETCH_ALIGN_CHECK_EN`.
- Defined: a `pc_load` with `pc_target[1:0]` != 0 is rejected. PC is unchanged, state is unchanged, and `misalign_err` pulses high for one cycle (the cycle after the request).
- Undefined: `pc_target[1:0]` is forced to 2'b00 on load, and `misalign_err` is tied 0.

## Test plan
- Reset with RESET_PC=32'h100, then `fetch_en` for 1 cycle, `imem_ack` in the first REQ cycle with rdata 32'h00500093 -> `imem_addr`=32'h100, `instr`=32'h00500093, `instr_valid`=1 two cycles after `fetch_en`.
- In VALID, `pc_inc` and `fetch_en` in the same cycle -> next `imem_addr`=32'h104 with `imem_req`=1; `pc_load`=1 with `pc_inc`=1 and target 32'h200 -> `pc`=32'h200.
- MAX_WAIT=4, never ack -> `fetch_err`=1 after exactly 4 REQ cycles, `imem_req`=0, `fetch_en` ignored; ack on the 4th cycle instead -> VALID, no error.
- `pc`=32'hFFFF_FFFC -> `pc_plus4`=0; `pc_inc` -> `pc`=0. `pc_load` during REQ -> `pc` unchanged.
- With FETCH_ALIGN_CHECK_EN, `pc_load` to 32'h202 -> `pc` unchanged, one-cycle `misalign_err`. Without it -> `pc`=32'h200.
- `rst_n` low during REQ, then a late ack -> `imem_req`=0, `instr_valid`=0, `instr`=32'h13, `pc`=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC owner and single-word instruction fetcher feeding the
//            multicycle control unit over an imem req/ack handshake.
//            Optional macro FETCH_ALIGN_CHECK_EN rejects misaligned loads.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        pc_inc,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [7:0]  c_last_wait = 8'(MAX_WAIT - 1);
    localparam logic [31:0] c_nop       = 32'h0000_0013;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [7:0]  r_wait;
    logic        r_req;
    logic        r_valid;
    logic        r_err;

    logic        w_upd_window;
    logic        w_misaligned;
    logic [31:0] w_target;
    logic        w_load;
    logic        w_inc;
    logic        w_pc_upd;

    assign w_upd_window = (r_state == S_IDLE) || (r_state == S_VALID);

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misalign;
    assign w_misaligned = pc_load && (pc_target[1:0] != 2'b00);
    assign w_target     = pc_target;
    assign misalign_err = r_misalign;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_misalign <= 1'b0;
        else
            r_misalign <= w_upd_window && w_misaligned;
    end
`else
    assign w_misaligned = 1'b0;
    assign w_target     = pc_target & 32'hFFFF_FFFC;
    assign misalign_err = 1'b0;
`endif

    // A load (even a rejected one) masks a simultaneous increment.
    assign w_load   = w_upd_window && pc_load && !w_misaligned;
    assign w_inc    = w_upd_window && pc_inc && !pc_load;
    assign w_pc_upd = w_load || w_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= c_nop;
            r_wait  <= 8'd0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_load)
                r_pc <= w_target;
            else if (w_inc)
                r_pc <= r_pc + 32'd4;

            case (r_state)
                S_IDLE: begin
                    if (fetch_en) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_wait  <= 8'd0;
                    end
                end
                S_REQ: begin
                    // An ack in the final allowed cycle still wins over timeout.
                    if (imem_ack) begin
                        r_state <= S_VALID;
                        r_instr <= imem_rdata;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                    end else if (r_wait == c_last_wait) begin
                        r_state <= S_ERR;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_VALID: begin
                    if (fetch_en) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_valid <= 1'b0;
                        r_wait  <= 8'd0;
                    end else if (w_pc_upd) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign fetch_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed plus random stimulus for instr_fetch_unit, compared
//            every cycle against a behavioural fetch model.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] c_reset_pc = 32'h0000_0100;
    localparam int          c_max_wait = 4;
    localparam int          M_IDLE = 0, M_BUSY = 1, M_HAVE = 2, M_DEAD = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0, pc_inc = 1'b0, pc_load = 1'b0;
    logic [31:0] pc_target = '0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] instr, pc, pc_plus4;
    logic        instr_valid, fetch_err, misalign_err;

    int n_pass = 0;
    int n_total = 0;

    // Reference model
    int          m_mode;
    int          m_wait;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_mis;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(c_reset_pc), .MAX_WAIT(c_max_wait)) u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .pc_inc(pc_inc),
        .pc_load(pc_load), .pc_target(pc_target), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_err(fetch_err), .misalign_err(misalign_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_edge();
        logic updated;
        if (!rst_n) begin
            m_mode = M_IDLE; m_wait = 0; m_pc = c_reset_pc;
            m_instr = 32'h13; m_mis = 1'b0;
            return;
        end
        m_mis = 1'b0;
        updated = 1'b0;
        case (m_mode)
            M_BUSY: begin
                if (imem_ack) begin
                    m_instr = imem_rdata;
                    m_mode  = M_HAVE;
                end else begin
                    m_wait++;
                    if (m_wait >= c_max_wait) m_mode = M_DEAD;
                end
            end
            M_IDLE, M_HAVE: begin
                if (pc_load) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (pc_target % 4 != 0) m_mis = 1'b1;
                    else begin m_pc = pc_target; updated = 1'b1; end
`else
                    m_pc = pc_target - (pc_target % 4);
                    updated = 1'b1;
`endif
                end else if (pc_inc) begin
                    m_pc = m_pc + 32'd4;
                    updated = 1'b1;
                end
                if (fetch_en) begin
                    m_mode = M_BUSY;
                    m_wait = 0;
                end else if (updated) begin
                    m_mode = M_IDLE;
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        check_eq("imem_req",     32'(imem_req),     32'(m_mode == M_BUSY));
        check_eq("imem_addr",    imem_addr,         m_pc);
        check_eq("pc",           pc,                m_pc);
        check_eq("pc_plus4",     pc_plus4,          m_pc + 32'd4);
        check_eq("instr_valid",  32'(instr_valid),  32'(m_mode == M_HAVE));
        check_eq("instr",        instr,             m_instr);
        check_eq("fetch_err",    32'(fetch_err),    32'(m_mode == M_DEAD));
        check_eq("misalign_err", 32'(misalign_err), 32'(m_mis));
    endtask

    task automatic cyc(input logic r, input logic fe, input logic inc, input logic ld,
                       input logic [31:0] tgt, input logic ak, input logic [31:0] rd);
        rst_n = r; fetch_en = fe; pc_inc = inc; pc_load = ld;
        pc_target = tgt; imem_ack = ak; imem_rdata = rd;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        logic r, fe, inc, ld, ak;
        logic [31:0] tgt;

        // Reset and first fetch
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check_eq("reset_pc", pc, 32'h100);
        check_eq("reset_instr", instr, 32'h13);
        cyc(1, 1, 0, 0, 0, 0, 0);
        check_eq("first_req", 32'(imem_req), 32'd1);
        check_eq("first_addr", imem_addr, 32'h100);
        cyc(1, 0, 0, 0, 0, 1, 32'h0050_0093);
        check_eq("first_instr", instr, 32'h0050_0093);
        check_eq("first_valid", 32'(instr_valid), 32'd1);

        // Increment with fetch, then load-over-inc priority
        cyc(1, 1, 1, 0, 0, 0, 0);
        check_eq("inc_fetch_addr", imem_addr, 32'h104);
        check_eq("inc_fetch_req", 32'(imem_req), 32'd1);
        cyc(1, 0, 0, 0, 0, 1, 32'h1234_5678);
        cyc(1, 0, 1, 1, 32'h200, 0, 0);
        check_eq("load_prio_pc", pc, 32'h200);
        check_eq("load_stale", 32'(instr_valid), 32'd0);

        // Misaligned target
        cyc(1, 0, 0, 1, 32'h202, 0, 0);
        check_eq("misalign_pc", pc, 32'h200);
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("misalign_pulse", 32'(misalign_err), 32'd1);
`else
        check_eq("misalign_tied", 32'(misalign_err), 32'd0);
`endif
        cyc(1, 0, 0, 0, 0, 0, 0);
        check_eq("misalign_clear", 32'(misalign_err), 32'd0);

        // Wrap-around and load dropped during REQ
        cyc(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        check_eq("wrap_plus4", pc_plus4, 32'h0);
        cyc(1, 0, 1, 0, 0, 0, 0);
        check_eq("wrap_inc", pc, 32'h0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 32'h300, 0, 0);
        check_eq("req_load_drop", pc, 32'h0);

        // Timeout after exactly MAX_WAIT un-acked cycles
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < c_max_wait - 1; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        check_eq("pre_timeout_req", 32'(imem_req), 32'd1);
        check_eq("pre_timeout_err", 32'(fetch_err), 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check_eq("timeout_err", 32'(fetch_err), 32'd1);
        check_eq("timeout_req", 32'(imem_req), 32'd0);
        cyc(1, 1, 1, 0, 0, 1, 32'hDEAD_BEEF);
        check_eq("err_ignores_fetch", 32'(imem_req), 32'd0);

        // Ack in the final allowed cycle beats the timeout
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < c_max_wait - 1; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 32'hCAFE_0013);
        check_eq("late_ack_valid", 32'(instr_valid), 32'd1);
        check_eq("late_ack_noerr", 32'(fetch_err), 32'd0);

        // Reset during REQ, late ack ignored
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h1111_1111);
        cyc(1, 0, 0, 0, 0, 1, 32'h2222_2222);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'h13);
        check_eq("rst_pc", pc, c_reset_pc);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r   = (m_mode == M_DEAD) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) != 0);
            fe  = ($urandom_range(0, 2) == 0);
            inc = ($urandom_range(0, 3) == 0);
            ld  = ($urandom_range(0, 5) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFFC;
            ak  = ($urandom_range(0, 1) == 0);
            cyc(r, fe, inc, ld, tgt, ak, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
